// File: rtl/urv_lsu.sv
// urv_lsu: load/store unit with a store buffer, blocking loads and load-data formatting
module urv_lsu #(
  parameter int SB_DEPTH        = 2,
  parameter int TRAP_MISALIGNED = 1,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  x_stall_i,
  input  logic                  x_kill_i,
  output logic                  x_stall_req_o,
  input  logic                  d_valid_i,
  input  logic                  d_is_load_i,
  input  logic                  d_is_store_i,
  input  logic [2:0]            d_fun_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_data_i,
  output logic                  x_misaligned_o,
  output logic                  x_sb_empty_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [31:0]           dm_data_s_o,
  output logic [3:0]            dm_data_select_o,
  output logic                  dm_load_o,
  output logic                  dm_store_o,
  input  logic                  dm_ready_i,
  input  logic                  dm_load_done_i,
  input  logic [31:0]           dm_data_l_i,
  output logic                  w_load_valid_o,
  output logic [31:0]           w_load_data_o
);
  localparam int CW = $clog2(SB_DEPTH + 1);
  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(SB_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic                  r_drop;
  logic [2:0]            r_fun;
  logic [1:0]            r_lsb;
  logic [CW-1:0]         r_cnt;
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [ADDR_WIDTH-1:0] r_sb_addr [SB_DEPTH];
  logic [31:0]           r_sb_data [SB_DEPTH];
  logic [3:0]            r_sb_sel  [SB_DEPTH];
  logic                  w_mis;
  logic                  w_ok;
  logic                  w_ld;
  logic                  w_st;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_sdata;
  logic [3:0]            w_ssel;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_fmt;

  // Qualify the request, flag misalignment, align the address and drive the bus from buffer head or load
  always_comb begin
    w_mis = (d_fun_i[1:0] == 2'b01 && d_addr_i[0]) || (d_fun_i[1:0] == 2'b10 && d_addr_i[1:0] != 2'b00);
    w_ok = !(TRAP_MISALIGNED != 0 && w_mis);
    w_ld = rst_n_i && d_valid_i && !x_kill_i && d_is_load_i && w_ok;
    w_st = rst_n_i && d_valid_i && !x_kill_i && d_is_store_i && w_ok;
    x_misaligned_o = TRAP_MISALIGNED != 0 && rst_n_i && d_valid_i && !x_kill_i && (d_is_load_i || d_is_store_i) && w_mis;
    w_addr = {d_addr_i[ADDR_WIDTH-1:2], d_addr_i[1] && !d_fun_i[1], d_addr_i[0] && d_fun_i[1:0] == 2'b00};
    w_sdata = d_fun_i[1:0] == 2'b00 ? {4{d_data_i[7:0]}} : d_fun_i[1:0] == 2'b01 ? {2{d_data_i[15:0]}} : d_data_i;
    w_ssel = d_fun_i[1:0] == 2'b00 ? 4'b0001 << w_addr[1:0] : d_fun_i[1:0] == 2'b01 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_full = r_cnt == FULL;
    dm_store_o = r_cnt != '0 && r_state != S_RESP;
    dm_load_o = r_state == S_IDLE && w_ld && r_cnt == '0;
    w_pop = dm_store_o && dm_ready_i;
    x_stall_req_o = (r_state == S_IDLE && w_ld) || r_state == S_RESP || (w_st && w_full);
    x_sb_empty_o = r_cnt == '0 && !dm_store_o;
    dm_addr_o = dm_store_o ? r_sb_addr[r_rp] : dm_load_o ? w_addr : '0;
    dm_data_s_o = dm_store_o ? r_sb_data[r_rp] : '0;
    dm_data_select_o = dm_store_o ? r_sb_sel[r_rp] : '0;
  end

  assign w_push = w_st && !x_stall_i && !w_full;
  assign w_load_valid_o = r_state == S_DONE && !x_stall_i && !x_kill_i;

  // Pick the addressed byte/half of the response and sign- or zero-extend it
  always_comb begin
    w_byte = 8'(dm_data_l_i >> {r_lsb, 3'b000});
    w_half = r_lsb[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    w_fmt = r_fun[1:0] == 2'b00 ? {{24{w_byte[7] && !r_fun[2]}}, w_byte} : r_fun[1:0] == 2'b01 ? {{16{w_half[15] && !r_fun[2]}}, w_half} : dm_data_l_i;
  end

  // Load FSM: issue only once the buffer has drained, await the response, hold the result until retire
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_drop <= 1'b0;
      r_fun <= '0;
      r_lsb <= '0;
      w_load_data_o <= '0;
    end else if (r_state == S_IDLE) begin
      if (dm_load_o && dm_ready_i) begin
        r_state <= S_RESP;
        r_drop <= 1'b0;
        r_fun <= d_fun_i;
        r_lsb <= w_addr[1:0];
      end
    end else if (r_state == S_RESP) begin
      if (x_kill_i) r_drop <= 1'b1;
      if (dm_load_done_i) begin
        r_state <= (r_drop || x_kill_i) ? S_IDLE : S_DONE;
        if (!(r_drop || x_kill_i)) w_load_data_o <= w_fmt;
      end
    end else if (!x_stall_i) begin
      r_state <= S_IDLE;
    end
  end

  // Store-buffer pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp == LAST ? '0 : r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp == LAST ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Store-buffer payload: word address, lane-replicated data and byte enables
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_sb_addr[r_wp] <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
      r_sb_data[r_wp] <= w_sdata;
      r_sb_sel[r_wp] <= w_ssel;
    end
  end
endmodule

// File: tb/tb_urv_lsu.sv
// tb_urv_lsu: directed bench for urv_lsu with a queue-level reference model (TRAP=1 and TRAP=0 instances)
module tb_urv_lsu;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;

  logic kill = 0, valid = 0, is_ld = 0, is_st = 0, ext = 0, rdy = 0, done = 0;
  logic [2:0] fun = 0;
  logic [31:0] addr = 0, sdata = 0, dl = 0;
  logic stall_req [2], mis [2], empty [2], ld_o [2], st_o [2], lv [2], x_stall [2];
  logic [31:0] a_o [2], ds_o [2], ld_data [2];
  logic [3:0] sel_o [2];
  int errors = 0, checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign x_stall[g] = stall_req[g] | ext;
    urv_lsu #(.SB_DEPTH(2), .TRAP_MISALIGNED(g == 0 ? 1 : 0), .ADDR_WIDTH(32)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(x_stall[g]), .x_kill_i(kill),
      .x_stall_req_o(stall_req[g]), .d_valid_i(valid), .d_is_load_i(is_ld),
      .d_is_store_i(is_st), .d_fun_i(fun), .d_addr_i(addr), .d_data_i(sdata),
      .x_misaligned_o(mis[g]), .x_sb_empty_o(empty[g]), .dm_addr_o(a_o[g]),
      .dm_data_s_o(ds_o[g]), .dm_data_select_o(sel_o[g]), .dm_load_o(ld_o[g]),
      .dm_store_o(st_o[g]), .dm_ready_i(rdy), .dm_load_done_i(done),
      .dm_data_l_i(dl), .w_load_valid_o(lv[g]), .w_load_data_o(ld_data[g]));
  end

  task automatic chk(input int k, input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s got=%h exp=%h t=%0t", k, n, got, exp, $time);
    end
  endtask

  // Reference model: pending stores as a list, load progress as a phase (0 idle, 1 waiting, 2 result held)
  logic [31:0] m_a [2][4], m_d [2][4];
  logic [3:0] m_s [2][4];
  int m_n [2] = '{0, 0};
  int ph [2] = '{0, 0};
  logic drop [2];
  logic [2:0] lf [2];
  logic [1:0] la [2];
  logic [31:0] res [2];

  function automatic logic [31:0] fmt(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (8 * a)) & 32'hFFFF;
    if (f[1:0] == 2'b10) return w;
    if (f[1:0] == 2'b00) return f[2] ? b : {{24{b[7]}}, b[7:0]};
    return f[2] ? h : {{16{h[15]}}, h[15:0]};
  endfunction

  task automatic model(input int k);
    logic trap, act, me, ok, ldr, str, es, el, est, xs, ev;
    logic [31:0] ea, dd;
    logic [3:0] sl;
    trap = (k == 0);
    if (!rst_n) begin
      m_n[k] = 0;
      ph[k] = 0;
      drop[k] = 0;
    end
    act = rst_n && valid && !kill;
    me = (fun[1:0] == 2'b01 && addr[0]) || (fun[1:0] == 2'b10 && addr[1:0] != 2'b00);
    ok = !(trap && me);
    ldr = act && is_ld && ok;
    str = act && is_st && ok;
    ea = addr;
    if (fun[1:0] == 2'b01) ea[0] = 1'b0;
    if (fun[1:0] == 2'b10) ea = ea & ~32'd3;
    es = m_n[k] > 0 && ph[k] != 1;
    el = ph[k] == 0 && ldr && m_n[k] == 0;
    est = (ph[k] == 0 && ldr) || ph[k] == 1 || (str && m_n[k] == 2);
    xs = est || ext;
    ev = ph[k] == 2 && !xs && !kill;
    chk(k, "misaligned", mis[k], trap && act && (is_ld || is_st) && me);
    chk(k, "stall_req", stall_req[k], est);
    chk(k, "store_req", st_o[k], es);
    chk(k, "load_req", ld_o[k], el);
    chk(k, "sb_empty", empty[k], m_n[k] == 0);
    chk(k, "load_valid", lv[k], ev);
    if (es) begin
      chk(k, "store_addr", a_o[k], m_a[k][0]);
      chk(k, "store_data", ds_o[k], m_d[k][0]);
      chk(k, "store_sel", sel_o[k], m_s[k][0]);
    end
    if (el) chk(k, "load_addr", a_o[k], ea);
    if (ev) chk(k, "load_data", ld_data[k], res[k]);
    if (!rst_n) return;
    if (es && rdy) begin
      for (int i = 0; i < 3; i++) begin
        m_a[k][i] = m_a[k][i+1];
        m_d[k][i] = m_d[k][i+1];
        m_s[k][i] = m_s[k][i+1];
      end
      m_n[k]--;
    end
    if (str && !xs) begin
      dd = fun[1:0] == 2'b00 ? {24'b0, sdata[7:0]} * 32'h01010101 : fun[1:0] == 2'b01 ? {16'b0, sdata[15:0]} * 32'h00010001 : sdata;
      sl = fun[1:0] == 2'b00 ? 4'b0001 << ea[1:0] : fun[1:0] == 2'b01 ? 4'b0011 << ea[1:0] : 4'b1111;
      m_a[k][m_n[k]] = ea & ~32'd3;
      m_d[k][m_n[k]] = dd;
      m_s[k][m_n[k]] = sl;
      m_n[k]++;
    end
    if (ph[k] == 0) begin
      if (el && rdy) begin
        ph[k] = 1;
        drop[k] = 0;
        lf[k] = fun;
        la[k] = ea[1:0];
      end
    end else if (ph[k] == 1) begin
      if (kill) drop[k] = 1;
      if (done) begin
        if (drop[k]) ph[k] = 0;
        else begin
          res[k] = fmt(lf[k], la[k], dl);
          ph[k] = 2;
        end
      end
    end else if (!xs) ph[k] = 0;
  endtask

  always @(negedge clk) begin
    model(0);
    model(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic l, input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    valid = l | s;
    is_ld = l;
    is_st = s;
    fun = f;
    addr = a;
    sdata = d;
  endtask

  task automatic two_stores();
    rdy = 0;
    op(0, 1, 3'b010, 32'h200, 32'h11);
    tick();
    op(0, 1, 3'b001, 32'h202, 32'hBEEF);
    tick();
  endtask

  task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w, input logic [31:0] e,
                         input logic hold, input string n, output int waited);
    op(1, 0, f, a, 0);
    rdy = 1;
    waited = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ld_o[0]) begin
        waited = i;
        break;
      end
      tick();
    end
    chk(0, {n, "_issued"}, waited >= 0, 1);
    tick();
    rdy = 0;
    done = 1;
    dl = w;
    tick();
    done = 0;
    op(0, 0, 0, 0, 0);
    ext = hold;
    if (hold) begin
      @(negedge clk);
      chk(0, {n, "_held"}, lv[0], 0);
      tick();
      ext = 0;
    end
    @(negedge clk);
    chk(0, {n, "_valid"}, lv[0], 1);
    chk(0, n, ld_data[0], e);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    #1 rst_n = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_empty", empty[k], 1);
      chk(k, "rst_stall", stall_req[k], 0);
      chk(k, "rst_store", st_o[k], 0);
      chk(k, "rst_load", ld_o[k], 0);
      chk(k, "rst_valid", lv[k], 0);
      chk(k, "rst_data", ld_data[k], 0);
    end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    op(0, 1, 3'b010, 32'h100, 32'h1);
    @(negedge clk);
    chk(0, "sw1_stall", stall_req[0], 0);
    tick();
    op(0, 1, 3'b010, 32'h104, 32'h2);
    @(negedge clk);
    chk(0, "sw2_stall", stall_req[0], 0);
    tick();
    op(0, 1, 3'b010, 32'h108, 32'h3);
    @(negedge clk);
    chk(0, "sw3_stall", stall_req[0], 1);
    chk(0, "sw3_head", a_o[0], 32'h100);
    tick();
    rdy = 1;
    @(negedge clk);
    chk(0, "full_no_bypass", stall_req[0], 1);
    tick();
    @(negedge clk);
    chk(0, "sw3_unstall", stall_req[0], 0);
    tick();
    op(0, 0, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    chk(0, "drained", empty[0], 1);
    rdy = 0;
    tick();
    op(0, 1, 3'b000, 32'h1003, 32'hA5);
    tick();
    op(0, 0, 0, 0, 0);
    @(negedge clk);
    chk(0, "sb_data", ds_o[0], 32'hA5A5A5A5);
    chk(0, "sb_sel", sel_o[0], 4'b1000);
    chk(0, "sb_addr", a_o[0], 32'h1000);
    tick();
    rdy = 1;
    tick();
    rdy = 0;
    @(negedge clk);
    chk(0, "sb_drained", empty[0], 1);
    tick();
    two_stores();
    do_load(3'b000, 32'h2001, 32'h00008000, 32'hFFFFFF80, 0, "lb", w);
    chk(0, "lb_waited", w, 2);
    two_stores();
    do_load(3'b100, 32'h2001, 32'h00008000, 32'h00000080, 1, "lbu", w);
    chk(0, "lbu_waited", w, 2);
    do_load(3'b101, 32'h2002, 32'h80FF0000, 32'h000080FF, 0, "lhu", w);
    do_load(3'b010, 32'h2004, 32'hCAFEF00D, 32'hCAFEF00D, 0, "lw", w);
    op(1, 0, 3'b001, 32'h3001, 0);
    rdy = 1;
    @(negedge clk);
    chk(0, "mis_flag", mis[0], 1);
    chk(0, "mis_noload", ld_o[0], 0);
    chk(0, "mis_nostall", stall_req[0], 0);
    chk(1, "fix_flag", mis[1], 0);
    chk(1, "fix_load", ld_o[1], 1);
    chk(1, "fix_addr", a_o[1], 32'h3000);
    tick();
    op(0, 0, 0, 0, 0);
    rdy = 0;
    done = 1;
    dl = 32'h1234ABCD;
    tick();
    done = 0;
    @(negedge clk);
    chk(1, "fix_valid", lv[1], 1);
    chk(1, "fix_data", ld_data[1], 32'hFFFFABCD);
    chk(0, "mis_novalid", lv[0], 0);
    tick();
    op(1, 0, 3'b010, 32'h400, 0);
    rdy = 1;
    @(negedge clk);
    chk(0, "kl_issue", ld_o[0], 1);
    tick();
    op(0, 0, 0, 0, 0);
    rdy = 0;
    kill = 1;
    tick();
    kill = 0;
    tick();
    done = 1;
    dl = 32'hDEADBEEF;
    tick();
    done = 0;
    @(negedge clk);
    chk(0, "kl_novalid", lv[0], 0);
    chk(0, "kl_nostall", stall_req[0], 0);
    tick();
    kill = 1;
    op(0, 1, 3'b010, 32'h600, 32'h6);
    @(negedge clk);
    chk(0, "kill_nostall", stall_req[0], 0);
    tick();
    kill = 0;
    op(0, 0, 0, 0, 0);
    @(negedge clk);
    chk(0, "kill_noenq", empty[0], 1);
    tick();
    op(0, 1, 3'b010, 32'h700, 32'h7);
    tick();
    op(0, 1, 3'b010, 32'h704, 32'h8);
    tick();
    op(1, 0, 3'b010, 32'h800, 0);
    @(negedge clk);
    chk(0, "pre_rst_stall", stall_req[0], 1);
    tick();
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "arst_empty", empty[k], 1);
      chk(k, "arst_store", st_o[k], 0);
      chk(k, "arst_load", ld_o[k], 0);
      chk(k, "arst_stall", stall_req[k], 0);
      chk(k, "arst_addr", a_o[k], 0);
    end
    tick();
    op(0, 0, 0, 0, 0);
    rst_n = 1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
